// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Both the top and the PC register sub-module import this package.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'h0000_0004;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetchState_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Fetch PC register: a 32-bit enable flop that asynchronously resets
// to the configured boot address.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: req/ready fetch handshake, word buffering
// while D is stalled, and delay-slot redirects resolved in D.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] pcjumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        fetch_waitF
);

    fetchState_e state_q, state_d;
    logic [31:0] buffer_q, buffer_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcPlus4_q, pcPlus4_d;
    logic        valid_q, valid_d;
    logic        redirPend_q, redirPend_d;
    logic [31:0] redirPc_q, redirPc_d;

    logic [31:0] pc;
    logic [31:0] pcPlus4F;
    logic [31:0] pcNext;
    logic [31:0] target;
    logic [31:0] word;
    logic        have;
    logic        advance;
    logic        redir;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en_i(advance),
        .d_i (pcNext),
        .q_o (pc)
    );

    assign pcPlus4F = pc + PC_STEP;

    // The word in F is always consumed (delay slot); a redirect only
    // steers the fetch that follows it, possibly after a memory wait.
    always_comb begin
        state_d     = state_q;
        buffer_d    = buffer_q;
        instr_d     = instr_q;
        pcPlus4_d   = pcPlus4_q;
        valid_d     = valid_q;
        redirPend_d = redirPend_q;
        redirPc_d   = redirPc_q;

        have    = ((state_q == S_REQ) && imem_ready) || (state_q == S_HOLD);
        word    = (state_q == S_HOLD) ? buffer_q : imem_rdata;
        advance = have && !stallD && !flushD;
        redir   = (jumpD || pcsrcD) && !stallD;
        target  = jumpD ? pcjumpD : pcbranchD;

        case (state_q)
            S_REQ: begin
                if (imem_ready && !advance) begin
                    buffer_d = imem_rdata;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (flushD) begin
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            pcPlus4_d = '0;
        end else if (stallD) begin
            instr_d   = instr_q;
        end else if (advance) begin
            instr_d   = word;
            pcPlus4_d = pcPlus4F;
            valid_d   = 1'b1;
        end else begin
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
        end

        if (redir && !advance) begin
            redirPend_d = 1'b1;
            redirPc_d   = target;
        end else if (advance) begin
            redirPend_d = 1'b0;
        end

        if (redir) begin
            pcNext = target;
        end else if (redirPend_q) begin
            pcNext = redirPc_q;
        end else begin
            pcNext = pcPlus4F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            buffer_q    <= '0;
            instr_q     <= NOP_INSTR;
            pcPlus4_q   <= '0;
            valid_q     <= 1'b0;
            redirPend_q <= 1'b0;
            redirPc_q   <= '0;
        end else begin
            state_q     <= state_d;
            buffer_q    <= buffer_d;
            instr_q     <= instr_d;
            pcPlus4_q   <= pcPlus4_d;
            valid_q     <= valid_d;
            redirPend_q <= redirPend_d;
            redirPc_q   <= redirPc_d;
        end
    end

    // Request is dropped the moment reset rises, even mid-handshake.
    assign imem_req    = (state_q == S_REQ) && !rst;
    assign imem_addr   = pc;
    assign pcF         = pc;
    assign instrD      = instr_q;
    assign pcplus4D    = pcPlus4_q;
    assign validD      = valid_q;
    assign fetch_waitF = (state_q == S_REQ) && !imem_ready;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake waits, stall buffering,
// delay-slot redirects, flush priority, async reset and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stallD;
    logic        flushD;
    logic        pcsrcD;
    logic        jumpD;
    logic [31:0] pcbranchD;
    logic [31:0] pcjumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic        fetch_waitF;

    int totalChecks = 0;
    int badChecks   = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stallD     (stallD),
        .flushD     (flushD),
        .pcsrcD     (pcsrcD),
        .jumpD      (jumpD),
        .pcbranchD  (pcbranchD),
        .pcjumpD    (pcjumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pcF        (pcF),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD),
        .fetch_waitF(fetch_waitF)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h8C00_0000 + addr;
    endfunction

    // Read data is garbage unless ready, so a stale buffer cannot hide.
    assign imem_rdata = imem_ready ? memWord(imem_addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic flush,
                                 input logic pcsrc, input logic jump,
                                 input logic [31:0] pcb, input logic [31:0] pcj,
                                 input logic rdy);
        stallD     = stall;
        flushD     = flush;
        pcsrcD     = pcsrc;
        jumpD      = jump;
        pcbranchD  = pcb;
        pcjumpD    = pcj;
        imem_ready = rdy;
        #1;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        tick;
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_pc", pcF, 32'h0);
        checkOutput("rst_instr", instrD, 32'h0);
        checkOutput("rst_valid", {31'b0, validD}, 32'd0);
        checkOutput("rst_pcplus4", pcplus4D, 32'h0);

        rst = 1'b0;
        #1;
        checkOutput("t1_req", {31'b0, imem_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t1_addr", imem_addr, 32'(4 * k));
            tick;
            checkOutput("t1_instr", instrD, memWord(32'(4 * k)));
            checkOutput("t1_pcplus4", pcplus4D, 32'(4 * k + 4));
            checkOutput("t1_valid", {31'b0, validD}, 32'd1);
        end

        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("t2_wait", {31'b0, fetch_waitF}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick;
            checkOutput("t2_bubble_valid", {31'b0, validD}, 32'd0);
            checkOutput("t2_bubble_instr", instrD, 32'h0);
            checkOutput("t2_addr_held", imem_addr, 32'h10);
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        checkOutput("t2_nowait", {31'b0, fetch_waitF}, 32'd0);
        tick;
        checkOutput("t2_instr", instrD, memWord(32'h10));
        checkOutput("t2_pc", pcF, 32'h14);

        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("t3_req_off", {31'b0, imem_req}, 32'd0);
        checkOutput("t3_hold_instr", instrD, memWord(32'h10));
        checkOutput("t3_hold_valid", {31'b0, validD}, 32'd1);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        tick;
        tick;
        checkOutput("t3_hold_instr2", instrD, memWord(32'h10));
        checkOutput("t3_pc_held", pcF, 32'h14);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
        tick;
        checkOutput("t3_buf_instr", instrD, memWord(32'h14));
        checkOutput("t3_pcplus4", pcplus4D, 32'h18);
        checkOutput("t3_req_on", {31'b0, imem_req}, 32'd1);
        checkOutput("t3_next_addr", imem_addr, 32'h18);

        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        tick;
        tick;
        checkOutput("t4_pre_pc", pcF, 32'h24);
        applyStimulus(0, 0, 0, 1, 32'h200, 32'h100, 1);
        tick;
        checkOutput("t4_slot_instr", instrD, memWord(32'h24));
        checkOutput("t4_slot_pcplus4", pcplus4D, 32'h28);
        checkOutput("t4_target_addr", imem_addr, 32'h100);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("t4_target_instr", instrD, memWord(32'h100));
        checkOutput("t4_target_pc", pcF, 32'h104);

        applyStimulus(0, 0, 1, 0, 32'h20, 32'h0, 1);
        tick;
        checkOutput("t4_br_slot", instrD, memWord(32'h104));
        checkOutput("t4_br_pc", pcF, 32'h20);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("t4_br_instr", instrD, memWord(32'h20));

        applyStimulus(0, 0, 1, 1, 32'h300, 32'h100, 0);
        tick;
        checkOutput("t4p_bubble", {31'b0, validD}, 32'd0);
        checkOutput("t4p_addr0", imem_addr, 32'h24);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
        tick;
        tick;
        checkOutput("t4p_addr2", imem_addr, 32'h24);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("t4p_slot_instr", instrD, memWord(32'h24));
        checkOutput("t4p_target_addr", imem_addr, 32'h100);
        tick;
        checkOutput("t4p_target_instr", instrD, memWord(32'h100));
        checkOutput("t4p_pc", pcF, 32'h104);

        applyStimulus(1, 1, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("t5_instr", instrD, 32'h0);
        checkOutput("t5_valid", {31'b0, validD}, 32'd0);
        checkOutput("t5_pcplus4", pcplus4D, 32'h0);
        checkOutput("t5_req_off", {31'b0, imem_req}, 32'd0);
        checkOutput("t5_pc", pcF, 32'h104);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
        tick;
        checkOutput("t5_kept_instr", instrD, memWord(32'h104));
        checkOutput("t5_kept_valid", {31'b0, validD}, 32'd1);
        checkOutput("t5_kept_pcplus4", pcplus4D, 32'h108);

        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("t6_wait", {31'b0, fetch_waitF}, 32'd1);
        tick;
        checkOutput("t6_req_pending", {31'b0, imem_req}, 32'd1);
        checkOutput("t6_addr_pending", imem_addr, 32'h108);
        rst = 1'b1;
        #1;
        checkOutput("t6_req_drop", {31'b0, imem_req}, 32'd0);
        checkOutput("t6_pc_reset", pcF, 32'h0);
        checkOutput("t6_valid_reset", {31'b0, validD}, 32'd0);
        tick;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        checkOutput("t6_req_again", {31'b0, imem_req}, 32'd1);
        checkOutput("t6_addr_again", imem_addr, 32'h0);
        tick;
        checkOutput("t6_first_instr", instrD, memWord(32'h0));
        checkOutput("t6_pc_next", pcF, 32'h4);

        applyStimulus(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 1);
        tick;
        checkOutput("wrap_pc_top", pcF, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        tick;
        checkOutput("wrap_instr", instrD, memWord(32'hFFFF_FFFC));
        checkOutput("wrap_pcplus4", pcplus4D, 32'h0);
        checkOutput("wrap_pc", pcF, 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
